// File: rtl/ifu_axi_fetch_pkg.sv
// Shared fetch-stage types and constants. IDU and CSR import the reset PC and
// NOP word from here so mepc/mcause handling agrees with the fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    NEXT = 2'd3
  } fetch_state_e;

  localparam logic [1:0]  FAULT_NONE     = 2'b00;
  localparam logic [1:0]  FAULT_BUS      = 2'b01;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b10;

  localparam logic [1:0]  RESP_OKAY      = 2'b00;

  localparam logic [31:0] DEF_RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] DEF_NOP_INST   = 32'h0000_0013;

endpackage

// File: rtl/ifu_axi_fetch_if.sv
// Fetch unit bus bundle: AR/R read channel, IDU handoff, next-PC return path
// and the fetch counter. master = fetch unit side, slave = memory/pipeline side.
interface ifu_axi_fetch_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  inst_fault;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_ready;
  logic [31:0] fetch_cnt;

  modport master (
    output araddr, arvalid, rready,
    output inst, pc, inst_valid, inst_fault,
    output upd_ready, fetch_cnt,
    input  arready, rdata, rresp, rvalid,
    input  inst_ready, upd_valid, upd_pc
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  inst, pc, inst_valid, inst_fault,
    input  upd_ready, fetch_cnt,
    output arready, rdata, rresp, rvalid,
    output inst_ready, upd_valid, upd_pc
  );
endinterface

// File: rtl/ifu_axi_fetch.sv
// Multi-cycle instruction fetch: one AR/R read per instruction, hand the word
// to IDU, then wait for the next PC from execute/writeback before refetching.
module ifu_axi_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic clk,
  input  logic rst,
  ifu_axi_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [1:0]   fault_q, fault_d;
  logic [31:0]  cnt_q, cnt_d;

  // State and datapath registers; reset abandons any outstanding AR or R.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      fault_q <= FAULT_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and handshake strobes; each handshake is only looked at in its
  // own state, so the four strobes are mutually exclusive by construction.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    fault_d        = fault_q;
    cnt_d          = cnt_q;
    bus.arvalid    = 1'b0;
    bus.araddr     = '0;
    bus.rready     = 1'b0;
    bus.inst_valid = 1'b0;
    bus.upd_ready  = 1'b0;
    case (state_q)
      REQ: begin
        // pc_q only moves in NEXT, so araddr is stable while arvalid is up
        bus.arvalid = 1'b1;
        bus.araddr  = pc_q;
        if (bus.arready) state_d = WAIT;
      end
      WAIT: begin
        bus.rready = 1'b1;
        if (bus.rvalid) begin
          if (bus.rresp == RESP_OKAY) begin
            inst_d  = bus.rdata;
            fault_d = FAULT_NONE;
          end else begin
            inst_d  = NOP_INST;
            fault_d = FAULT_BUS;
          end
          cnt_d   = cnt_q + 32'd1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        bus.inst_valid = 1'b1;
        if (bus.inst_ready) state_d = NEXT;
      end
      NEXT: begin
        bus.upd_ready = 1'b1;
        if (bus.upd_valid) begin
          pc_d = bus.upd_pc;
          // misaligned target: report it to IDU without touching the bus
          if (bus.upd_pc[1:0] != 2'b00) begin
            inst_d  = NOP_INST;
            fault_d = FAULT_MISALIGN;
            state_d = HOLD;
          end else begin
            state_d = REQ;
          end
        end
      end
      default: state_d = REQ;
    endcase
  end

  assign bus.inst       = inst_q;
  assign bus.pc         = pc_q;
  assign bus.inst_fault = fault_q;
  assign bus.fetch_cnt  = cnt_q;

endmodule
